// File: rtl/sr_axis_pkg.sv
// Shared types and constants for the RGB565 AXI-Stream tile datapath.
package sr_axis_pkg;
  localparam int PIX565_W     = 16;
  localparam int PIX_PER_BEAT = 4;
  localparam int BEAT_W       = PIX565_W * PIX_PER_BEAT;

  typedef logic [PIX565_W-1:0] pix565_t;
  typedef logic [BEAT_W-1:0]   beat_t;

  // RGB565 field positions: R[15:11], G[10:5], B[4:0]
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam int DEFAULT_TILE_W = 28;
  localparam int DEFAULT_TILE_H = 28;

  // Pixel 'lane' of a beat; lane 0 sits in the least significant bits.
  function automatic pix565_t beat_lane(input beat_t beat, input logic [1:0] lane);
    return beat[PIX565_W*lane +: PIX565_W];
  endfunction
endpackage

// File: rtl/rgb565_axis_serializer_if.sv
// Beat-in / pixel-out stream bundle of the RGB565 serializer.
interface rgb565_axis_serializer_if;
  import sr_axis_pkg::*;

  // Both sides use AXI-Stream rules: a transfer happens on a rising edge where
  // valid && ready; valid never waits on ready, and payload is held while valid && !ready.
  logic    s_tvalid;
  logic    s_tready;
  logic    s_tlast;
  logic    [7:0] s_tkeep;
  beat_t   s_tdata;
  logic    m_tvalid;
  logic    m_tready;
  pix565_t m_tdata;
  logic    m_tuser;
  logic    m_teol;
  logic    m_tlast;

  modport slave (
    input  s_tvalid, s_tlast, s_tkeep, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tuser, m_teol, m_tlast
  );

  modport master (
    output s_tvalid, s_tlast, s_tkeep, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tuser, m_teol, m_tlast
  );
endinterface

// File: rtl/rgb565_tile_counter.sv
// Column/row position inside a TILE_W x TILE_H tile with SOF/EOL/EOT decode.
module rgb565_tile_counter #(
  parameter int TILE_W = 28,
  parameter int TILE_H = 28,
  parameter int CW     = (TILE_W > 1) ? $clog2(TILE_W) : 1,
  parameter int RW     = (TILE_H > 1) ? $clog2(TILE_H) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          resync,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          is_sof,
  output logic          is_eol,
  output logic          is_eot
);
  localparam logic [CW-1:0] COL_LAST = CW'(TILE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TILE_H - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (resync) begin
        col <= '0;
        row <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign is_sof = (col == '0) && (row == '0);
  assign is_eol = (col == COL_LAST);
  assign is_eot = is_eol && (row == ROW_LAST);
endmodule

// File: rtl/rgb565_axis_serializer.sv
// Splits 4-pixel RGB565 beats into a 1 pixel/cycle stream with tile position
// markers and sticky checks of upstream tlast/tkeep against the tile geometry.
module rgb565_axis_serializer
  import sr_axis_pkg::*;
#(
  parameter int TILE_W = DEFAULT_TILE_W,
  parameter int TILE_H = DEFAULT_TILE_H
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  rgb565_axis_serializer_if.slave        bus,
  input  logic                           clr_err,
  output logic                           err_tlast_early,
  output logic                           err_tlast_miss,
  output logic                           err_keep
);
  beat_t      hold_data;
  logic       hold_last;
  logic       hold_valid;
  logic [1:0] lane;

  logic accept;
  logic xfer;
  logic beat_done;
  logic is_sof;
  logic is_eol;
  logic is_eot;
  logic set_early;
  logic set_miss;
  logic set_keep;

  // Ready also when the last lane leaves this cycle, so beats chain without a bubble.
  assign bus.s_tready = !hold_valid || ((lane == 2'd3) && bus.m_tready);
  assign accept       = bus.s_tvalid && bus.s_tready;
  assign xfer         = hold_valid && bus.m_tready;
  assign beat_done    = xfer && (lane == 2'd3);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_valid <= 1'b0;
      lane       <= 2'd0;
    end else if (accept) begin
      hold_data  <= bus.s_tdata;
      hold_last  <= bus.s_tlast;
      hold_valid <= 1'b1;
      lane       <= 2'd0;
    end else if (xfer) begin
      lane <= lane + 2'd1;
      if (lane == 2'd3) hold_valid <= 1'b0;
    end
  end

  assign bus.m_tvalid = hold_valid;
  assign bus.m_tdata  = beat_lane(hold_data, lane);
  assign bus.m_tuser  = is_sof;
  assign bus.m_teol   = is_eol;
  assign bus.m_tlast  = is_eot;

  // tlast is only judged when a whole beat has left; lane 3 always lines up with
  // row ends because TILE_W is a whole number of beats.
  assign set_early = beat_done && hold_last && !is_eot;
  assign set_miss  = beat_done && is_eot && !hold_last;
  assign set_keep  = accept && (bus.s_tkeep != 8'hFF);

  rgb565_tile_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_tile_counter (
    .clk     (aclk),
    .rst_n   (aresetn),
    .advance (xfer),
    .resync  (set_early),
    .col     (),
    .row     (),
    .is_sof  (is_sof),
    .is_eol  (is_eol),
    .is_eot  (is_eot)
  );

  // Sticky flags: a new error in the clearing cycle survives the clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_tlast_early <= 1'b0;
      err_tlast_miss  <= 1'b0;
      err_keep        <= 1'b0;
    end else begin
      if (set_early)    err_tlast_early <= 1'b1;
      else if (clr_err) err_tlast_early <= 1'b0;
      if (set_miss)     err_tlast_miss  <= 1'b1;
      else if (clr_err) err_tlast_miss  <= 1'b0;
      if (set_keep)     err_keep        <= 1'b1;
      else if (clr_err) err_keep        <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rgb565_axis_serializer.sv
// Directed + randomized bench for rgb565_axis_serializer on an 8x2 tile
// against a pixel-position reference model.
module tb_rgb565_axis_serializer;
  import sr_axis_pkg::*;

  localparam int TW        = 8;
  localparam int TH        = 2;
  localparam int TILE_PIX  = TW * TH;
  localparam int MAX_CYC   = 400;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic clr_err = 1'b0;
  logic err_tlast_early;
  logic err_tlast_miss;
  logic err_keep;

  always #5 aclk = ~aclk;

  rgb565_axis_serializer_if bus();

  rgb565_axis_serializer #(
    .TILE_W (TW),
    .TILE_H (TH)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .bus             (bus),
    .clr_err         (clr_err),
    .err_tlast_early (err_tlast_early),
    .err_tlast_miss  (err_tlast_miss),
    .err_keep        (err_keep)
  );

  // ---------------- scoreboard / model state ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [18:0] exp_q[$];            // {tuser, teol, tlast, pixel}
  logic [63:0] beat_data[$];
  logic        beat_last[$];
  logic [7:0]  beat_keep[$];

  int   model_pos = 0;              // linear pixel index inside the tile
  logic exp_early = 1'b0;
  logic exp_miss  = 1'b0;
  logic exp_keep  = 1'b0;

  int first_acc_cyc;
  int first_xfer_cyc;
  int last_xfer_cyc;
  int ready_low;
  int sof_cnt;
  int eol_cnt;
  int tlast_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: each pixel's markers follow from its index in the tile; beat tlast
  // is judged against whether the beat's final pixel is the tile's final pixel.
  task automatic model_accept(input logic [63:0] data, input logic last, input logic [7:0] keep);
    logic [15:0] pix;
    logic        tile_end;
    if (keep != 8'hFF) exp_keep = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pix = data[16*k +: 16];
      exp_q.push_back({(model_pos == 0), ((model_pos % TW) == TW - 1),
                       (model_pos == TILE_PIX - 1), pix});
      if (k == 3) begin
        tile_end = (model_pos == TILE_PIX - 1);
        if (last && !tile_end) begin
          exp_early = 1'b1;
          model_pos = 0;
        end else begin
          if (tile_end && !last) exp_miss = 1'b1;
          model_pos = (model_pos + 1) % TILE_PIX;
        end
      end else begin
        model_pos = model_pos + 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_beat(input logic [63:0] data, input logic last, input logic [7:0] keep);
    beat_data.push_back(data);
    beat_last.push_back(last);
    beat_keep.push_back(keep);
  endtask

  task automatic add_tile(input int last_beat_idx);
    for (int b = 0; b < 4; b++)
      add_beat({$urandom, $urandom}, (b == last_beat_idx), 8'hFF);
  endtask

  // mode 0: m_tready=1; mode 1: 1,0,0 repeating; mode 2: random
  task automatic run_stream(input int mode);
    int          n;
    int          bi;
    int          cyc;
    logic        stalled;
    logic [18:0] saved;
    logic [18:0] obs;
    logic [18:0] e;
    n = beat_data.size();
    bi = 0;
    cyc = 0;
    stalled = 1'b0;
    saved = '0;
    first_acc_cyc = -1;
    first_xfer_cyc = -1;
    last_xfer_cyc = -1;
    ready_low = 0;
    sof_cnt = 0;
    eol_cnt = 0;
    tlast_cnt = 0;
    while ((bi < n || exp_q.size() != 0) && cyc < MAX_CYC) begin
      @(negedge aclk);
      if (bi < n) begin
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = beat_data[bi];
        bus.s_tlast  = beat_last[bi];
        bus.s_tkeep  = beat_keep[bi];
      end else begin
        bus.s_tvalid = 1'b0;
      end
      case (mode)
        0:       bus.m_tready = 1'b1;
        1:       bus.m_tready = ((cyc % 3) == 0);
        default: bus.m_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      obs = {bus.m_tuser, bus.m_teol, bus.m_tlast, bus.m_tdata};
      if (stalled) check("stall_hold", {bus.m_tvalid, obs}, {1'b1, saved});
      if (bus.m_tvalid && bus.m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", obs, 19'h0);
          total_cnt++;
          $error("FAIL unexpected_pixel observed=%h expected=none", obs);
        end else begin
          e = exp_q.pop_front();
          check("pixel", obs, e);
        end
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        if (!bus.s_tready) ready_low++;
        if (bus.m_tuser) sof_cnt++;
        if (bus.m_teol)  eol_cnt++;
        if (bus.m_tlast) tlast_cnt++;
      end
      stalled = bus.m_tvalid && !bus.m_tready;
      saved = obs;
      if (bus.s_tvalid && bus.s_tready) begin
        model_accept(beat_data[bi], beat_last[bi], beat_keep[bi]);
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        bi++;
      end
      cyc++;
    end
    check("stream_done", {31'(bi), 32'(exp_q.size())}, {31'(n), 32'd0});
    @(negedge aclk);
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b1;
    #1;
    beat_data.delete();
    beat_last.delete();
    beat_keep.delete();
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_early"}, err_tlast_early, exp_early);
    check({tag, "_err_miss"},  err_tlast_miss,  exp_miss);
    check({tag, "_err_keep"},  err_keep,        exp_keep);
  endtask

  task automatic pulse_clr();
    @(negedge aclk);
    clr_err = 1'b1;
    @(negedge aclk);
    clr_err = 1'b0;
    #1;
    exp_early = 1'b0;
    exp_miss  = 1'b0;
    exp_keep  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tkeep  = 8'hFF;
    bus.s_tdata  = '0;
    bus.m_tready = 1'b1;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rst_m_tvalid", bus.m_tvalid, 1'b0);
    check("rst_m_tdata",  bus.m_tdata,  16'h0);
    check("rst_s_tready", bus.s_tready, 1'b1);
    check_errs("rst");

    // 1: single beat, lane order and SOF on first pixel only
    add_beat(64'h4444_3333_2222_1111, 1'b0, 8'hFF);
    run_stream(0);
    check("t1_latency", 32'(first_xfer_cyc - first_acc_cyc), 32'd1);
    check("t1_sof_cnt", sof_cnt, 1);
    add_beat({$urandom, $urandom}, 1'b0, 8'hFF);
    add_beat({$urandom, $urandom}, 1'b0, 8'hFF);
    add_beat({$urandom, $urandom}, 1'b1, 8'hFF);
    run_stream(0);
    check_errs("t1");

    // 2: full tile back-to-back, no bubbles
    add_tile(3);
    run_stream(0);
    check("t2_span",      32'(last_xfer_cyc - first_xfer_cyc), 32'd15);
    check("t2_ready_low", ready_low, 12);
    check("t2_eol_cnt",   eol_cnt,   2);
    check("t2_tlast_cnt", tlast_cnt, 1);
    check_errs("t2");

    // 3: same tile shape under 1,0,0 backpressure
    add_tile(3);
    run_stream(1);
    check("t3_tlast_cnt", tlast_cnt, 1);
    check_errs("t3");

    // 4: early tlast on the second beat, then a clean tile
    add_beat({$urandom, $urandom}, 1'b0, 8'hFF);
    add_beat({$urandom, $urandom}, 1'b1, 8'hFF);
    add_tile(3);
    run_stream(0);
    check("t4_sof_cnt", sof_cnt, 2);
    check_errs("t4");
    pulse_clr();
    check_errs("t4_clr");

    // 5: missing tlast, then a short-keep beat
    add_tile(-1);
    run_stream(0);
    check_errs("t5_miss");
    pulse_clr();
    add_beat({$urandom, $urandom}, 1'b0, 8'h0F);
    add_beat({$urandom, $urandom}, 1'b0, 8'hFF);
    add_beat({$urandom, $urandom}, 1'b0, 8'hFF);
    add_beat({$urandom, $urandom}, 1'b1, 8'hFF);
    run_stream(2);
    check_errs("t5_keep");
    pulse_clr();

    // 6: reset after pixel 2222 has been taken
    @(negedge aclk);
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 64'h4444_3333_2222_1111;
    bus.s_tlast  = 1'b0;
    bus.s_tkeep  = 8'hFF;
    bus.m_tready = 1'b1;
    @(negedge aclk);
    bus.s_tvalid = 1'b0;
    #1;
    check("t6_pix0", {bus.m_tuser, bus.m_tdata}, {1'b1, 16'h1111});
    @(negedge aclk);
    #1;
    check("t6_pix1", bus.m_tdata, 16'h2222);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("t6_rst_m_tvalid", bus.m_tvalid, 1'b0);
    check("t6_rst_m_tdata",  bus.m_tdata,  16'h0);
    exp_q.delete();
    model_pos = 0;
    exp_early = 1'b0;
    exp_miss  = 1'b0;
    exp_keep  = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("t6_s_tready", bus.s_tready, 1'b1);
    add_tile(3);
    run_stream(0);
    check("t6_sof_cnt", sof_cnt, 1);
    check_errs("t6");

    // 7: three tiles under random backpressure
    add_tile(3);
    add_tile(3);
    add_tile(3);
    run_stream(2);
    check("t7_tlast_cnt", tlast_cnt, 3);
    check_errs("t7");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
